t05_spi_sclk_gen: RTL and testbench

//  Parametrised SPI serial-clock generator; successor to the fixed two-speed divider.

---
 rtl/t05_spi_sclk_gen.sv | 187 ++++++++++++++++++
 tb/tb_t05_spi_sclk_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/t05_spi_sclk_gen.sv
// SPI serial-clock burst generator: nbits SCLK periods at a selectable half-period,
// CPOL/CPHA modes 0-3, and one-cycle shift/sample strobes for the data shifter.
module t05_spi_sclk_gen #(
  parameter int unsigned DIV_W     = 10,
  parameter int unsigned SLOW_HALF = 100,
  parameter int unsigned FAST_HALF = 2,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             current_clock_signal,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             freq_flag,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [CNT_W-1:0] nbits,
  output logic             sclk,
  output logic             shift_stb,
  output logic             sample_stb,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] SLOW_M1 = DIV_W'(SLOW_HALF - 1);
  localparam logic [DIV_W-1:0] FAST_M1 = DIV_W'(FAST_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_TRAIL = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   nbits_q, nbits_d;
  logic               fast_q, fast_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               sclk_q, sclk_d;
  logic               shift_q, shift_d;
  logic               sample_q, sample_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DIV_W-1:0]   half_m1;
  logic               half_wrap;
  logic [CNT_W-1:0]   bit_inc;
  logic               last_bit;

  assign half_m1   = fast_q ? FAST_M1 : SLOW_M1;
  assign half_wrap = (half_cnt_q == half_m1);
  assign bit_inc   = bit_cnt_q + CNT_W'(1);
  assign last_bit  = (bit_inc == nbits_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    fast_d     = fast_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (start && !abort) begin
          nbits_d    = nbits;
          fast_d     = freq_flag;
          cpol_d     = cpol;
          cpha_d     = cpha;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          if (nbits == '0) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
          end else begin
            state_d = S_LEAD;
            busy_d  = 1'b1;
            shift_d = !cpha;
          end
        end
      end

      S_LEAD: begin
        if (abort) begin
          state_d    = S_IDLE;
          sclk_d     = cpol_q;
          busy_d     = 1'b0;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
        end else if (half_wrap) begin
          half_cnt_d = '0;
          sclk_d     = !cpol_q;
          shift_d    = cpha_q;
          sample_d   = !cpha_q;
          state_d    = S_TRAIL;
        end else begin
          half_cnt_d = half_cnt_q + DIV_W'(1);
        end
      end

      S_TRAIL: begin
        if (abort) begin
          state_d    = S_IDLE;
          sclk_d     = cpol_q;
          busy_d     = 1'b0;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
        end else if (half_wrap) begin
          half_cnt_d = '0;
          sclk_d     = cpol_q;
          sample_d   = cpha_q;
          bit_cnt_d  = bit_inc;
          if (last_bit) begin
            state_d = S_FIN;
          end else begin
            shift_d = !cpha_q;
            state_d = S_LEAD;
          end
        end else begin
          half_cnt_d = half_cnt_q + DIV_W'(1);
        end
      end

      // One settling cycle after the last trailing edge; abort still suppresses done
      S_FIN: begin
        state_d    = S_IDLE;
        sclk_d     = cpol_q;
        busy_d     = 1'b0;
        half_cnt_d = '0;
        bit_cnt_d  = '0;
        done_d     = !(abort && busy_q);
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge current_clock_signal or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= '0;
      fast_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      shift_q    <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      nbits_q    <= nbits_d;
      fast_q     <= fast_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign shift_stb  = shift_q;
  assign sample_stb = sample_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_t05_spi_sclk_gen.sv
// Scoreboard bench for t05_spi_sclk_gen: stimulus pushes expected edge/strobe events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_t05_spi_sclk_gen;

  localparam int unsigned CNT_W = 6;
  localparam int SLOW_H = 100;
  localparam int FAST_H = 2;

  typedef struct {
    int   cyc;
    logic sclk;
    logic shift;
    logic sample;
    logic done;
    logic busy;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             freq_flag = 1'b0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [CNT_W-1:0] nbits = '0;
  logic             sclk, shift_stb, sample_stb, busy, done;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic sclk_prev = 1'b0;
  logic busy_prev = 1'b0;
  ev_t  exp_q[$];

  t05_spi_sclk_gen dut (
    .current_clock_signal(clk),
    .reset(rst),
    .start(start),
    .abort(abort),
    .freq_flag(freq_flag),
    .cpol(cpol),
    .cpha(cpha),
    .nbits(nbits),
    .sclk(sclk),
    .shift_stb(shift_stb),
    .sample_stb(sample_stb),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any strobe, done, busy change or sclk change around a burst is an event
  always @(negedge clk) begin
    ev_t e;
    logic trig;
    trig = shift_stb | sample_stb | done | (busy != busy_prev) |
           ((sclk != sclk_prev) & (busy | busy_prev));
    if (mon_en && trig) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL evt_unexpected: got cyc=%0d sclk=%b sh=%b sa=%b dn=%b bz=%b, expected no event",
                 cyc, sclk, shift_stb, sample_stb, done, busy);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.sclk !== sclk || e.shift !== shift_stb ||
            e.sample !== sample_stb || e.done !== done || e.busy !== busy) begin
          n_fail++;
          $display("FAIL evt: got cyc=%0d sclk=%b sh=%b sa=%b dn=%b bz=%b, expected cyc=%0d sclk=%b sh=%b sa=%b dn=%b bz=%b",
                   cyc, sclk, shift_stb, sample_stb, done, busy,
                   e.cyc, e.sclk, e.shift, e.sample, e.done, e.busy);
        end
      end
    end
    sclk_prev = sclk;
    busy_prev = busy;
  end

  task automatic add_ev(input int c, input logic s, input logic sh, input logic sa,
                        input logic dn, input logic bz, input int ea);
    ev_t e;
    if (ea == 0 || c < ea) begin
      e.cyc = c; e.sclk = s; e.shift = sh; e.sample = sa; e.done = dn; e.busy = bz;
      exp_q.push_back(e);
    end
  endtask

  // Expected events for a burst accepted at e0; ea = abort edge (0 = none)
  task automatic push_burst(input int e0, input logic cp, input logic ph, input int h,
                            input int n, input int ea);
    ev_t e;
    if (n == 0) begin
      add_ev(e0 + 1, cp, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      return;
    end
    add_ev(e0, cp, !ph, 1'b0, 1'b0, 1'b1, ea);
    for (int k = 0; k < n; k++) begin
      add_ev(e0 + h * (2 * k + 1), !cp, ph, !ph, 1'b0, 1'b1, ea);
      add_ev(e0 + h * (2 * k + 2), cp, (!ph && k != n - 1), ph, 1'b0, 1'b1, ea);
    end
    add_ev(e0 + 2 * h * n + 1, cp, 1'b0, 1'b0, 1'b1, 1'b0, ea);
    if (ea != 0) begin
      e.cyc = ea; e.sclk = cp; e.shift = 1'b0; e.sample = 1'b0; e.done = 1'b0; e.busy = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns with cyc == e0 (one negedge after acceptance)
  task automatic launch(input logic cp, input logic ph, input logic ff, input int nb,
                        input int ea_off, output int e0);
    cpol = cp; cpha = ph; freq_flag = ff; nbits = CNT_W'(nb);
    start = 1'b1;
    e0 = cyc + 1;
    push_burst(e0, cp, ph, ff ? FAST_H : SLOW_H, nb, (ea_off == 0) ? 0 : e0 + ea_off);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d events pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int e0, e0b;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_shift", shift_stb, 1'b0);
    check("rst_sample", sample_stb, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Mode 0 fast, 8 bits, then a back-to-back start in the done cycle
    launch(1'b0, 1'b0, 1'b1, 8, 0, e0);
    check("m0_busy_e0", busy, 1'b1);
    wait_cyc(e0 + 32);
    check("m0_busy_e32", busy, 1'b1);
    @(negedge clk);
    check("m0_done_e33", done, 1'b1);
    check("m0_busy_e33", busy, 1'b0);
    launch(1'b0, 1'b0, 1'b1, 8, 0, e0b);
    wait_cyc(e0b + 40);

    // Start re-pulsed while busy with different config: must be ignored
    launch(1'b0, 1'b0, 1'b1, 8, 0, e0);
    wait_cyc(e0 + 4);
    start = 1'b1; nbits = CNT_W'(3); cpol = 1'b1; freq_flag = 1'b0; cpha = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e0 + 45);
    cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(negedge clk);

    // Mode 3 slow, 2 bits
    launch(1'b1, 1'b1, 1'b0, 2, 0, e0);
    wait_cyc(e0 + 100);
    check("m3_sclk_fall", sclk, 1'b0);
    wait_cyc(e0 + 410);
    cpol = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-burst: sampled at E0+11
    launch(1'b0, 1'b0, 1'b1, 8, 11, e0);
    wait_cyc(e0 + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sclk", sclk, 1'b0);
    wait_cyc(e0 + 45);

    // Abort coincident with the final trailing edge (mode 1, 2 bits)
    launch(1'b0, 1'b1, 1'b1, 2, 8, e0);
    wait_cyc(e0 + 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_cyc(e0 + 20);

    // Abort and start together in IDLE: nothing accepted
    start = 1'b1; abort = 1'b1; nbits = CNT_W'(4);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    repeat (20) @(negedge clk);

    // nbits = 0: done at E0+1, busy never rises
    launch(1'b0, 1'b0, 1'b1, 0, 0, e0);
    check("n0_busy", busy, 1'b0);
    repeat (6) @(negedge clk);

    // Reset mid-burst while sclk is high
    launch(1'b0, 1'b0, 1'b1, 8, 0, e0);
    wait_cyc(e0 + 3);
    check("pre_rst_sclk", sclk, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (40) @(negedge clk);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending events, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
